// File: rtl/conv_pkg.sv
// Shared types and constants for the coefficient loader and its APB transfer engine.
package conv_pkg;
    localparam int         CONV_WORD_W          = 32;
    localparam int         CONV_TIMEOUT_DEFAULT = 64;
    localparam logic [3:0] CONV_STRB_ALL        = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ACCESS = 3'd3,
        ST_NEXT   = 3'd4,
        ST_DONE   = 3'd5
    } conv_ldr_state_t;

    typedef enum logic {
        PASS_WR = 1'b0,
        PASS_RD = 1'b1
    } conv_pass_t;

    typedef enum logic [1:0] {
        PH_IDLE   = 2'd0,
        PH_SETUP  = 2'd1,
        PH_ACCESS = 2'd2
    } apb_phase_t;
endpackage

// File: rtl/apb_master_xfer.sv
// Single-transfer APB master: SETUP then ACCESS, with an ACCESS-phase timeout.
module apb_master_xfer
    import conv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = CONV_TIMEOUT_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   go,
    input  logic                   write,
    input  logic [CONV_WORD_W-1:0] addr,
    input  logic [CONV_WORD_W-1:0] wdata,
    output logic                   ack,
    output logic                   timeout,
    output logic                   m_sel,
    output logic                   m_ce,
    output logic                   m_we,
    output logic [CONV_WORD_W-1:0] m_addr,
    output logic [CONV_WORD_W-1:0] m_wdata,
    output logic [3:0]             m_strb,
    input  logic                   m_rdy
);
    localparam int            CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    apb_phase_t             phase_r;
    logic [CW-1:0]          cnt_r;
    logic                   sel_r, ce_r, we_r;
    logic [CONV_WORD_W-1:0] addr_r, wdata_r;
    logic [3:0]             strb_r;
    logic                   access_s, cnt_last_s;

    // Completion and timeout decode for the current ACCESS cycle
    always_comb begin
        access_s   = (phase_r == PH_ACCESS);
        cnt_last_s = (cnt_r == CNT_LAST);
        ack        = access_s && m_rdy;
        timeout    = access_s && !m_rdy && cnt_last_s;
    end

    // Bus phase sequencing; every bus output is a flop
    always_ff @(posedge clk) begin
        if (!rstn) begin
            phase_r <= PH_IDLE;
            cnt_r   <= CW'(0);
            sel_r   <= 1'b0;
            ce_r    <= 1'b0;
            we_r    <= 1'b0;
            addr_r  <= 32'd0;
            wdata_r <= 32'd0;
            strb_r  <= 4'd0;
        end else begin
            case (phase_r)
                PH_IDLE: begin
                    if (go) begin
                        sel_r   <= 1'b1;
                        ce_r    <= 1'b0;
                        we_r    <= write;
                        addr_r  <= addr;
                        strb_r  <= CONV_STRB_ALL;
                        phase_r <= PH_SETUP;
                    end else begin
                        phase_r <= PH_IDLE;
                    end
                end
                PH_SETUP: begin
                    // ROM word only becomes valid during SETUP, so data lands with the enable
                    ce_r    <= 1'b1;
                    wdata_r <= wdata;
                    cnt_r   <= CW'(0);
                    phase_r <= PH_ACCESS;
                end
                PH_ACCESS: begin
                    if (m_rdy || cnt_last_s) begin
                        sel_r   <= 1'b0;
                        ce_r    <= 1'b0;
                        we_r    <= 1'b0;
                        addr_r  <= 32'd0;
                        wdata_r <= 32'd0;
                        strb_r  <= 4'd0;
                        phase_r <= PH_IDLE;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                default: begin
                    sel_r   <= 1'b0;
                    ce_r    <= 1'b0;
                    strb_r  <= 4'd0;
                    phase_r <= PH_IDLE;
                end
            endcase
        end
    end

    assign m_sel   = sel_r;
    assign m_ce    = ce_r;
    assign m_we    = we_r;
    assign m_addr  = addr_r;
    assign m_wdata = wdata_r;
    assign m_strb  = strb_r;
endmodule

// File: rtl/conv_coef_loader.sv
// Loads one ROM coefficient set into the convolution core over APB, optionally
// verifies it by read-back, and gates the core's data_enable on a clean load.
module conv_coef_loader
    import conv_pkg::*;
#(
    parameter int CONV_CORE_DEPTH = 256,
    parameter int NUM_SETS        = 4,
    parameter int TIMEOUT_CYCLES  = CONV_TIMEOUT_DEFAULT,
    parameter bit VERIFY          = 1'b1
) (
    input  logic                                   clk,
    input  logic                                   rstn,
    input  logic                                   start,
    input  logic [$clog2(NUM_SETS)-1:0]            set_sel,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   err,
    output logic [$clog2(CONV_CORE_DEPTH)-1:0]     err_idx,
    output logic                                   data_enable,
    output logic [$clog2(NUM_SETS*CONV_CORE_DEPTH)-1:0] rom_addr,
    input  logic [CONV_WORD_W-1:0]                 rom_rdata,
    output logic                                   m_sel,
    output logic                                   m_ce,
    output logic                                   m_we,
    output logic [CONV_WORD_W-1:0]                 m_addr,
    output logic [CONV_WORD_W-1:0]                 m_wdata,
    output logic [3:0]                             m_strb,
    input  logic                                   m_rdy,
    input  logic [CONV_WORD_W-1:0]                 m_rdata
);
    localparam int            IW       = $clog2(CONV_CORE_DEPTH);
    localparam int            SW       = $clog2(NUM_SETS);
    localparam int            AW       = $clog2(NUM_SETS * CONV_CORE_DEPTH);
    localparam logic [IW-1:0] IDX_LAST = IW'(CONV_CORE_DEPTH - 1);
    localparam logic [AW-1:0] DEPTH_A  = AW'(CONV_CORE_DEPTH);

    conv_ldr_state_t        state_r;
    conv_pass_t             pass_r;
    logic [SW-1:0]          set_r;
    logic [IW-1:0]          idx_r, err_idx_r;
    logic [CONV_WORD_W-1:0] exp_r;
    logic [AW-1:0]          rom_addr_r;
    logic                   busy_r, done_r, err_r, de_r;
    logic                   xfer_go_s, xfer_we_s, xfer_ack_s, xfer_tmo_s, mismatch_s;
    logic [CONV_WORD_W-1:0] xfer_addr_s;

    function automatic logic [AW-1:0] rom_index(input logic [SW-1:0] set, input logic [IW-1:0] idx);
        return AW'(set) * DEPTH_A + AW'(idx);
    endfunction

    // Transfer request and read-back compare for the current word
    always_comb begin
        xfer_go_s   = (state_r == ST_FETCH);
        xfer_we_s   = (pass_r == PASS_WR);
        xfer_addr_s = CONV_WORD_W'(idx_r);
        mismatch_s  = (pass_r == PASS_RD) && (m_rdata != exp_r);
    end

    apb_master_xfer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_xfer (
        .clk    (clk),
        .rstn   (rstn),
        .go     (xfer_go_s),
        .write  (xfer_we_s),
        .addr   (xfer_addr_s),
        .wdata  (rom_rdata),
        .ack    (xfer_ack_s),
        .timeout(xfer_tmo_s),
        .m_sel  (m_sel),
        .m_ce   (m_ce),
        .m_we   (m_we),
        .m_addr (m_addr),
        .m_wdata(m_wdata),
        .m_strb (m_strb),
        .m_rdy  (m_rdy)
    );

    // Load sequencer: word indexing, write/read passes, error capture
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r    <= ST_IDLE;
            pass_r     <= PASS_WR;
            set_r      <= SW'(0);
            idx_r      <= IW'(0);
            exp_r      <= 32'd0;
            rom_addr_r <= AW'(0);
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            err_idx_r  <= IW'(0);
            de_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        set_r      <= set_sel;
                        idx_r      <= IW'(0);
                        pass_r     <= PASS_WR;
                        err_r      <= 1'b0;
                        err_idx_r  <= IW'(0);
                        de_r       <= 1'b0;
                        busy_r     <= 1'b1;
                        rom_addr_r <= rom_index(set_sel, IW'(0));
                        state_r    <= ST_FETCH;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_FETCH: state_r <= ST_SETUP;
                ST_SETUP: begin
                    exp_r   <= rom_rdata;
                    state_r <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (xfer_ack_s) begin
                        if (mismatch_s && !err_r) begin
                            err_r     <= 1'b1;
                            err_idx_r <= idx_r;
                        end
                        state_r <= ST_NEXT;
                    end else if (xfer_tmo_s) begin
                        err_r     <= 1'b1;
                        err_idx_r <= idx_r;
                        busy_r    <= 1'b0;
                        done_r    <= 1'b1;
                        state_r   <= ST_DONE;
                    end else begin
                        state_r <= ST_ACCESS;
                    end
                end
                ST_NEXT: begin
                    if (idx_r == IDX_LAST) begin
                        if ((pass_r == PASS_WR) && VERIFY) begin
                            pass_r     <= PASS_RD;
                            idx_r      <= IW'(0);
                            rom_addr_r <= rom_index(set_r, IW'(0));
                            state_r    <= ST_FETCH;
                        end else begin
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            state_r <= ST_DONE;
                        end
                    end else begin
                        idx_r      <= idx_r + IW'(1);
                        rom_addr_r <= rom_index(set_r, idx_r + IW'(1));
                        state_r    <= ST_FETCH;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    de_r    <= !err_r;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign err         = err_r;
    assign err_idx     = err_idx_r;
    assign data_enable = de_r;
    assign rom_addr    = rom_addr_r;
endmodule

// File: tb/tb_conv_coef_loader.sv
// Directed bench for conv_coef_loader with an 8-tap, 2-set ROM and a configurable core model.
module tb_conv_coef_loader;
    logic        clk = 1'b0;
    logic        rstn, start;
    logic [0:0]  set_sel;
    logic        busy, done, err, data_enable;
    logic [2:0]  err_idx;
    logic [3:0]  rom_addr;
    logic [31:0] rom_rdata;
    logic        m_sel, m_ce, m_we, m_rdy;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_strb;

    int n_cmp = 0;
    int n_bad = 0;
    int wait_cyc = 0;
    int bad_idx = -1;
    int stuck_idx = -1;
    logic log_clr = 1'b1;
    int cyc = 0, wcnt = 0, wr_n = 0, rd_n = 0;
    int done_n = 0, t_busy = 0, t_done = 0, ce3_n = 0, strb_bad = 0;
    logic busy_q = 1'b0, done_msel = 1'b0;
    logic [31:0] wr_addr [0:15];
    logic [31:0] wr_data [0:15];
    logic [31:0] mem [0:7];

    always #5 clk = ~clk;

    conv_coef_loader #(
        .CONV_CORE_DEPTH(8),
        .NUM_SETS       (2),
        .TIMEOUT_CYCLES (64),
        .VERIFY         (1'b1)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .set_sel    (set_sel),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_idx    (err_idx),
        .data_enable(data_enable),
        .rom_addr   (rom_addr),
        .rom_rdata  (rom_rdata),
        .m_sel      (m_sel),
        .m_ce       (m_ce),
        .m_we       (m_we),
        .m_addr     (m_addr),
        .m_wdata    (m_wdata),
        .m_strb     (m_strb),
        .m_rdy      (m_rdy),
        .m_rdata    (m_rdata)
    );

    // ROM: word = A500_0000 + set*16 + idx, one cycle latency
    always @(posedge clk)
        rom_rdata <= 32'hA500_0000 + 32'(rom_addr[3]) * 32'd16 + 32'(rom_addr[2:0]);

    always_comb begin
        m_rdy   = m_sel && m_ce && (wcnt >= wait_cyc) && (int'(m_addr) != stuck_idx);
        m_rdata = mem[m_addr[2:0]] ^ ((int'(m_addr) == bad_idx) ? 32'h0000_0100 : 32'h0000_0000);
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (m_sel && m_ce && !m_rdy) wcnt <= wcnt + 1;
        else wcnt <= 0;
        if (log_clr) begin
            wr_n <= 0;
            rd_n <= 0;
            for (int i = 0; i < 8; i++) mem[i] <= 32'd0;
        end else if (m_sel && m_ce && m_rdy) begin
            if (m_we) begin
                mem[m_addr[2:0]] <= m_wdata;
                if (wr_n < 16) begin
                    wr_addr[wr_n] <= m_addr;
                    wr_data[wr_n] <= m_wdata;
                end
                wr_n <= wr_n + 1;
            end else begin
                rd_n <= rd_n + 1;
            end
        end
    end

    always @(negedge clk) begin
        busy_q <= busy;
        if (busy && !busy_q) t_busy <= cyc;
        if (done) begin
            done_n    <= done_n + 1;
            t_done    <= cyc;
            done_msel <= m_sel;
        end
        if (log_clr) ce3_n <= 0;
        else if (m_ce && m_addr == 32'd3) ce3_n <= ce3_n + 1;
        if ((m_sel && m_strb != 4'hF) || (!m_sel && m_strb != 4'h0)) strb_bad <= strb_bad + 1;
    end

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic clear_log();
        @(negedge clk);
        log_clr = 1'b1;
        @(negedge clk);
        log_clr = 1'b0;
    endtask

    task automatic kick(input logic s);
        @(negedge clk);
        set_sel = s;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n0;
        n0 = done_n;
        for (int i = 0; i < budget && done_n == n0; i++) @(negedge clk);
        chk_eq("done_seen", 32'(done_n - n0), 32'd1);
    endtask

    task automatic check_words(input int set, input int n);
        for (int i = 0; i < n; i++) begin
            chk_eq($sformatf("wr_addr%0d", i), wr_addr[i], 32'(i));
            chk_eq($sformatf("wr_data%0d", i), wr_data[i], 32'hA500_0000 + 32'(set * 16 + i));
        end
    endtask

    initial begin
        int nd;
        rstn    = 1'b0;
        start   = 1'b0;
        set_sel = 1'b0;
        repeat (3) @(negedge clk);
        chk_eq("rst_ctl", 32'({busy, done, err, data_enable, m_sel, m_ce, m_we}), 32'd0);
        chk_eq("rst_err_idx", 32'(err_idx), 32'd0);
        chk_eq("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk_eq("rst_bus", m_addr | m_wdata | 32'(m_strb), 32'd0);
        rstn = 1'b1;

        // Zero-wait load of set 1 with verify
        clear_log();
        kick(1'b1);
        wait_done(200);
        @(negedge clk);
        chk_eq("t1_wr_n", 32'(wr_n), 32'd8);
        check_words(1, 8);
        chk_eq("t1_rd_n", 32'(rd_n), 32'd8);
        chk_eq("t1_cycles", 32'(t_done - t_busy), 32'd64);
        chk_eq("t1_err", 32'(err), 32'd0);
        chk_eq("t1_de", 32'(data_enable), 32'd1);
        chk_eq("t1_busy", 32'(busy), 32'd0);

        // Two wait states per ACCESS
        wait_cyc = 2;
        clear_log();
        kick(1'b1);
        wait_done(400);
        @(negedge clk);
        chk_eq("t2_cycles", 32'(t_done - t_busy), 32'd96);
        chk_eq("t2_wr_n", 32'(wr_n), 32'd8);
        check_words(1, 8);
        chk_eq("t2_de", 32'(data_enable), 32'd1);
        wait_cyc = 0;

        // Read-back corruption at word 5, set 0
        bad_idx = 5;
        clear_log();
        kick(1'b0);
        wait_done(200);
        @(negedge clk);
        check_words(0, 8);
        chk_eq("t3_err", 32'(err), 32'd1);
        chk_eq("t3_err_idx", 32'(err_idx), 32'd5);
        chk_eq("t3_rd_n", 32'(rd_n), 32'd8);
        chk_eq("t3_cycles", 32'(t_done - t_busy), 32'd64);
        chk_eq("t3_de", 32'(data_enable), 32'd0);
        bad_idx = -1;

        // Ready stuck low at word 3 -> timeout abort
        stuck_idx = 3;
        clear_log();
        kick(1'b1);
        chk_eq("t4_err_cleared", 32'(err), 32'd0);
        wait_done(300);
        chk_eq("t4_err", 32'(err), 32'd1);
        chk_eq("t4_err_idx", 32'(err_idx), 32'd3);
        chk_eq("t4_access_cycles", 32'(ce3_n), 32'd64);
        chk_eq("t4_wr_n", 32'(wr_n), 32'd3);
        chk_eq("t4_sel_at_done", 32'(done_msel), 32'd0);
        chk_eq("t4_cycles", 32'(t_done - t_busy), 32'd78);
        @(negedge clk);
        chk_eq("t4_de", 32'(data_enable), 32'd0);
        stuck_idx = -1;

        // Second start during word 2 is ignored
        clear_log();
        nd = done_n;
        kick(1'b0);
        for (int i = 0; i < 50 && !(m_sel && m_addr == 32'd2); i++) @(negedge clk);
        chk_eq("t5_idx2_seen", 32'(m_sel && m_addr == 32'd2), 32'd1);
        set_sel = 1'b1;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        wait_done(200);
        @(negedge clk);
        chk_eq("t5_wr_n", 32'(wr_n), 32'd8);
        check_words(0, 8);
        repeat (10) @(negedge clk);
        chk_eq("t5_no_requeue", 32'(busy), 32'd0);
        chk_eq("t5_done_count", 32'(done_n - nd), 32'd1);
        chk_eq("t5_de", 32'(data_enable), 32'd1);

        // Reset during ACCESS of word 4, then a clean reload
        wait_cyc = 2;
        clear_log();
        kick(1'b1);
        for (int i = 0; i < 100 && !(m_ce && m_addr == 32'd4); i++) @(negedge clk);
        chk_eq("t6_idx4_seen", 32'(m_ce && m_addr == 32'd4), 32'd1);
        rstn = 1'b0;
        @(negedge clk);
        chk_eq("t6_rst_ctl", 32'({busy, done, err, data_enable, m_sel, m_ce, m_we}), 32'd0);
        chk_eq("t6_rst_bus", m_addr | m_wdata | 32'(m_strb) | 32'(rom_addr) | 32'(err_idx), 32'd0);
        chk_eq("t6_wr_n", 32'(wr_n), 32'd4);
        rstn = 1'b1;
        nd = done_n;
        repeat (5) @(negedge clk);
        chk_eq("t6_no_done", 32'(done_n - nd), 32'd0);
        chk_eq("t6_de", 32'(data_enable), 32'd0);
        wait_cyc = 0;
        clear_log();
        kick(1'b0);
        wait_done(200);
        @(negedge clk);
        chk_eq("t6_reload_wr_n", 32'(wr_n), 32'd8);
        check_words(0, 8);
        chk_eq("t6_reload_de", 32'(data_enable), 32'd1);

        chk_eq("strb_protocol", 32'(strb_bad), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/conv_coef_loader.md
# conv_coef_loader

Sequencer that loads a selected coefficient set from a local coefficient ROM into `convolution_core` through the core's APB-style configuration port, then optionally reads it back to verify. It sits between the system control logic and the convolution core and owns the core's `data_enable`, holding the datapath off while coefficients are inconsistent. Supports `NUM_SETS` stored filter sets, switched at run time with one `start` pulse.

## Interface
- `CONV_CORE_DEPTH`, 256: taps per set; core word addresses are 0..DEPTH-1.
- `NUM_SETS`, 4: coefficient sets held in the ROM.
- `TIMEOUT_CYCLES`, 64: maximum ACCESS-phase wait for `m_rdy`.
- `VERIFY`, 1: when 1, run a read-back compare pass after the write pass.

Ports:
- `clk`  in  1  single clock.
- `rstn`  in  1  reset, synchronous and active-low.
- `start`  in  1  load request, sampled only in IDLE.
- `set_sel`  in  $clog2(NUM_SETS)  set to load, latched on accepted `start`.
- `busy`  out  1  high from the cycle after `start` until DONE.
- `done`  out  1  one-cycle pulse at end of load.
- `err`  out  1  sticky until the next accepted `start`.
- `err_idx`  out  $clog2(CONV_CORE_DEPTH)  index of the first failing word.
- `data_enable`  out  1  drives the core's `data_enable`.
- `rom_addr`  out  $clog2(NUM_SETS*CONV_CORE_DEPTH)  equals `set*DEPTH + idx`.
- `rom_rdata`  in  32  ROM data, valid 1 cycle after `rom_addr`.
- `m_sel`, `m_ce`, `m_we`  out  1  APB select, enable and write to the core.
- `m_addr`  out  32  word index, zero-extended.
- `m_wdata`  out  32  write data.
- `m_strb`  out  4  4'b1111 during a transfer, otherwise 0.
- `m_rdy`  in  1  core ready.
- `m_rdata`  in  32  core read data.

## Operation
- **States:** IDLE, FETCH, SETUP, ACCESS, NEXT, DONE. Pass flag is WR or RD.
- **IDLE:**
  - On `start`: latch `set_sel`, set `idx`=0 and pass=WR.
  - Clear `err` and `err_idx`, drop `data_enable`, then go to FETCH.
- **FETCH:** drive `rom_addr`; 1 cycle.
- **SETUP:**
  - Assert `m_sel`=1, `m_ce`=0 and `m_we`=(pass==WR).
  - Set `m_addr`=`idx` and `m_wdata`=`rom_rdata`.
  - Register the ROM word into `exp_q`.
- **ACCESS:**
  - Assert `m_ce`=1 with all other bus outputs held.
  - Leave on the first cycle with `m_rdy`=1. That cycle is the last with `m_sel`/`m_ce` high.
  - In an RD pass, compare `m_rdata` with `exp_q` in that cycle. On mismatch with `err`=0, set `err`=1 and `err_idx`=`idx`; the pass continues.
- **NEXT:**
  - Bus is idle: all `m_*` outputs are 0.
  - If `idx`==DEPTH-1: after a WR pass with VERIFY=1, go to FETCH with pass=RD and `idx`=0; otherwise go to DONE.
  - Else `idx`++ and go to FETCH.
- **Timeout:** ACCESS lasting TIMEOUT_CYCLES cycles without `m_rdy` does the following:
  - Sets `err`=1 and `err_idx`=`idx` (overwriting any earlier compare error).
  - Drops the bus on the next edge and jumps to DONE (abort).
- **DONE:** `done`=1 for one cycle, then IDLE. `data_enable` becomes 1 in IDLE only if `err`=0; otherwise it stays 0.
- **`start` while busy:** ignored; no queuing.
- **Reset values:**
  - `busy`, `done`, `err`, `err_idx`, `data_enable` and every `m_*` output are 0; `rom_addr` is 0; state is IDLE.
  - `data_enable` stays 0 until the first successful load.
- **Reset mid-transfer:** the bus drops at the reset edge, with no completion of the pending APB access. The core contents are then undefined and `data_enable` stays 0.

## Timing
- Per word: FETCH, SETUP, ACCESS (1 + wait cycles), NEXT. That is 4 cycles with a zero-wait slave.
- Zero-wait write pass takes 4*DEPTH cycles; with VERIFY=1 the load takes 8*DEPTH.
- `busy` rises the edge after `start`. `done` rises one cycle after the final NEXT. `data_enable` rises one cycle after `done`.
- Bus outputs are registered with no combinational path from `m_rdy` to outputs. The timeout counter resets on each SETUP.

## Structure
- **Package `conv_pkg`:**
  - State enum `conv_ldr_state_t`.
  - `CONV_STRB_ALL` = 4'b1111.
  - Default `TIMEOUT_CYCLES`.
  - Word width constant 32.
- **Sub-module `apb_master_xfer`:**
  - Single-transfer APB master: request/ack, write/read, timeout output.
  - Owns SETUP/ACCESS and the timeout counter; the loader keeps indexing, passes and the compare.

## Test plan
Bench uses DEPTH=8, NUM_SETS=2, and ROM word = `{set, idx}` pattern 32'hA500_0000 + set*16 + idx.

- **Load set 1, zero-wait core model, VERIFY=1:**
  - Writes to addr 0..7 carry 32'hA500_0010..0017.
  - Read-back matches, `done` comes 64 cycles after `busy`, then `data_enable`=1 and `err`=0.
- **`m_rdy` held low 2 cycles each ACCESS:** write pass takes 6*8=48 cycles; data and order are unchanged.
- **Core model corrupts addr 5 on read:** `err`=1, `err_idx`=5, all 8 reads still issued, `data_enable`=0 after `done`.
- **`m_rdy` stuck low at idx 3:**
  - Abort after 64 ACCESS cycles with `err`=1 and `err_idx`=3.
  - `m_sel` is 0 the next cycle and `done` pulses.
- **Second `start` at idx 2 of a load:** ignored; exactly 8 writes occur and `set_sel` is unchanged.
- **`rstn`=0 during ACCESS of idx 4:**
  - All outputs are 0 the next cycle and there is no `done`.
  - A new `start` then reloads from idx 0.
